// File: rtl/rc5_pkg.sv
// Shared RC5-32/12/16 constants and the key-schedule FSM state type,
// used by the key schedule and the encoder/decoder datapaths.
package rc5_pkg;

    localparam int W = 32;
    localparam int R = 12;
    localparam int B = 16;
    localparam int T = 2 * (R + 1);
    localparam int C = B / 4;
    localparam int MIX_ITERS = 3 * ((T > C) ? T : C);

    localparam logic [W-1:0] PW = 32'hB7E1_5163;
    localparam logic [W-1:0] QW = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } rc5_state_t;

endpackage

// File: rtl/rc5_rotl.sv
// Variable left-rotate of a W-bit word by a 5-bit amount; shared with the
// encoder round stage.
module rc5_rotl #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic [4:0]   amt,
    output logic [W-1:0] dout
);

    logic [2*W-1:0] dbl;

    // The upper half of the doubled word shifted left is the rotated word.
    assign dbl  = {din, din} << amt;
    assign dout = dbl[2*W-1:W];

endmodule

// File: rtl/rc5_key_schedule.sv
// RC5-32/12/16 key expansion: builds the 26-word S table from a 128-bit key
// in 104 busy cycles and serves it to the encoder through a read port.
//
// state   | meaning
// IDLE    | waiting for start, table (if any) stays readable
// INIT    | filling S with PW + k*QW, one word per cycle
// MIX     | 78 mixing iterations over S and L
// DONE    | one-cycle done pulse, start accepted again here
module rc5_key_schedule
    import rc5_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [8*B-1:0] key_in,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           key_valid,
    input  logic [4:0]     rd_addr,
    output logic [W-1:0]   rd_data
);

    localparam logic [4:0] T_LAST   = 5'(T - 1);
    localparam logic [6:0] MIX_LAST = 7'(MIX_ITERS - 1);

    rc5_state_t     state;
    logic [W-1:0]   s_tab [T];
    logic [W-1:0]   l_tab [C];
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   init_val;
    logic [4:0]     i_idx;
    logic [1:0]     j_idx;
    logic [6:0]     mix_cnt;

    logic [W-1:0]   sum_a;
    logic [W-1:0]   a_new;
    logic [W-1:0]   sum_b;
    logic [W-1:0]   ab_sum;
    logic [W-1:0]   b_new;
    logic           accept;

    assign accept = rst && start && !busy;

    assign sum_a  = s_tab[i_idx] + a_reg + b_reg;
    assign ab_sum = a_new + b_reg;
    assign sum_b  = l_tab[j_idx] + ab_sum;

    rc5_rotl #(.W(W)) u_rotl_a (.din(sum_a), .amt(5'd3),        .dout(a_new));
    rc5_rotl #(.W(W)) u_rotl_b (.din(sum_b), .amt(ab_sum[4:0]), .dout(b_new));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            mix_cnt   <= '0;
            init_val  <= PW;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_INIT;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        i_idx     <= '0;
                        init_val  <= PW;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_INIT: begin
                    init_val <= init_val + QW;
                    if (i_idx == T_LAST) begin
                        state   <= ST_MIX;
                        i_idx   <= '0;
                        j_idx   <= '0;
                        a_reg   <= '0;
                        b_reg   <= '0;
                        mix_cnt <= '0;
                    end else begin
                        i_idx <= i_idx + 5'd1;
                    end
                end
                ST_MIX: begin
                    a_reg <= a_new;
                    b_reg <= b_new;
                    i_idx <= (i_idx == T_LAST) ? 5'd0 : i_idx + 5'd1;
                    j_idx <= j_idx + 2'd1;
                    if (mix_cnt == MIX_LAST) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end else begin
                        mix_cnt <= mix_cnt + 7'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Table storage carries no reset; key_valid gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < C; i++) begin
                l_tab[i] <= {key_in[127-8*(4*i+3) -: 8], key_in[127-8*(4*i+2) -: 8],
                             key_in[127-8*(4*i+1) -: 8], key_in[127-8*(4*i)   -: 8]};
            end
        end else if (rst && state == ST_MIX) begin
            l_tab[j_idx] <= b_new;
        end
        if (rst && state == ST_INIT) begin
            s_tab[i_idx] <= init_val;
        end else if (rst && state == ST_MIX) begin
            s_tab[i_idx] <= a_new;
        end
    end

    assign rd_data = (key_valid && rd_addr <= T_LAST) ? s_tab[rd_addr] : '0;

endmodule

// File: tb/tb_rc5_key_schedule.sv
// Self-checking bench for rc5_key_schedule: random keys against a software
// key-schedule model, timing of busy/done, restart and reset corner cases.
module tb_rc5_key_schedule;

    localparam logic [31:0] PW_C = 32'hB7E1_5163;
    localparam logic [31:0] QW_C = 32'h9E37_79B9;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         start;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_data;

    int vectors;
    int miscompares;
    logic [31:0] tbl_read [26];

    rc5_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic void key_sched(input logic [127:0] k, output logic [31:0] s [26]);
        logic [7:0]  kb [16];
        logic [31:0] l [4];
        logic [31:0] a;
        logic [31:0] b;
        int i;
        int j;
        for (int n = 0; n < 16; n++) kb[n] = k[127-8*n -: 8];
        for (int w = 0; w < 4; w++) l[w] = {kb[4*w+3], kb[4*w+2], kb[4*w+1], kb[4*w]};
        s[0] = PW_C;
        for (int t = 1; t < 26; t++) s[t] = s[t-1] + QW_C;
        a = 0; b = 0; i = 0; j = 0;
        for (int it = 0; it < 78; it++) begin
            a = rotl32(s[i] + a + b, 3);
            b = rotl32(l[j] + a + b, int'((a + b) & 32'd31));
            s[i] = a;
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns just after the posedge that sampled start.
    task automatic start_run(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = rand_key();
    endtask

    // Counts negedges after the start edge until done; optional stray start
    // at cycle inject_n and an INIT-end probe of the raw table.
    task automatic wait_done(input int inject_n, input logic [127:0] other, input bit probe);
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = (n == inject_n);
            if (n == inject_n) key_in = other;
            if (busy) busy_cnt++;
            if (probe && n == 27) begin
                check("init_s0", dut.s_tab[0], 32'hB7E1_5163);
                check("init_s1", dut.s_tab[1], 32'h5618_CB1C);
                check("init_s25", dut.s_tab[25], PW_C + 32'(25) * QW_C);
            end
            if (done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
        check("done_cycle", 32'(done_at), 32'd105);
        check("busy_cycles", 32'(busy_cnt), 32'd104);
        check("valid_with_done", {31'd0, key_valid}, 32'd1);
    endtask

    task automatic check_table(input logic [127:0] k);
        logic [31:0] s [26];
        key_sched(k, s);
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 32'd0);
        check("valid_hold", {31'd0, key_valid}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            if (a < 26) begin
                tbl_read[a] = rd_data;
                check($sformatf("s_word%0d", a), rd_data, s[a]);
            end else begin
                check($sformatf("oor_addr%0d", a), rd_data, 32'h0);
            end
        end
    endtask

    task automatic encrypt_zero(output logic [31:0] ca, output logic [31:0] cb);
        ca = tbl_read[0];
        cb = tbl_read[1];
        for (int r = 1; r <= 12; r++) begin
            ca = rotl32(ca ^ cb, int'(cb & 32'd31)) + tbl_read[2*r];
            cb = rotl32(cb ^ ca, int'(ca & 32'd31)) + tbl_read[2*r+1];
        end
    endtask

    initial begin
        logic [127:0] k1;
        logic [31:0]  ca;
        logic [31:0]  cb;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        start   = 1'b1;
        key_in  = '0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_rd", rd_data, 32'h0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("start_in_rst_ignored", {31'd0, busy}, 32'd0);

        start_run('0);
        wait_done(0, '0, 1'b1);
        check_table('0);
        encrypt_zero(ca, cb);
        check("ct_a", ca, 32'hEEDB_A521);
        check("ct_b", cb, 32'h6D8F_4B15);

        for (int t = 0; t < 100; t++) begin
            k1 = rand_key();
            start_run(k1);
            wait_done(0, '0, 1'b0);
            check_table(k1);
        end

        k1 = rand_key();
        start_run(k1);
        wait_done(40, rand_key(), 1'b0);
        check_table(k1);

        start_run(rand_key());
        wait_done(0, '0, 1'b0);
        k1 = rand_key();
        start_run(k1);
        check("restart_valid_low", {31'd0, key_valid}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(0, '0, 1'b0);
        check_table(k1);

        start_run(rand_key());
        repeat (60) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_addr = 5'd0;
        #1;
        check("mixrst_busy", {31'd0, busy}, 32'd0);
        check("mixrst_valid", {31'd0, key_valid}, 32'd0);
        check("mixrst_rd", rd_data, 32'h0);
        @(negedge clk);
        k1 = rand_key();
        start_run(k1);
        wait_done(0, '0, 1'b0);
        check_table(k1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rc5_key_schedule.md
RC5_KEY_SCHEDULE -- requirements
Module: rc5_key_schedule

Interface
REQ-001 SHALL use parameters: W 32 (word width, bits); R 12 (rounds); B 16 (key bytes); T 2*(R+1)=26 (S-table words); C B/4=4 (L words).
REQ-002 SHALL expose ports: clk input 1, the single clock, all logic on rising edge.
REQ-003 SHALL expose port: rst input 1, reset, synchronous and active-low.
REQ-004 SHALL expose ports: key_in input 128, secret key; byte K[n] = key_in[127-8n -: 8].
REQ-005 SHALL expose ports: start input 1, single-cycle request to expand key_in.
REQ-006 SHALL expose ports: busy output 1, expansion in progress.
REQ-007 SHALL expose ports: done output 1, one-cycle pulse marking expansion complete.
REQ-008 SHALL expose ports: key_valid output 1, the S table holds a completed schedule.
REQ-009 SHALL expose ports: rd_addr input 5, S-table index for the downstream RC5 encoder; rd_data output 32, S[rd_addr], combinational.

Function
REQ-010 SHALL implement FSM IDLE -> INIT -> MIX -> DONE -> IDLE.
REQ-011 SHALL accept start only when busy=0 (IDLE or DONE); start while busy=1 SHALL be ignored.
REQ-012 On accepted start SHALL latch L[i] = {K[4i+3],K[4i+2],K[4i+1],K[4i]} for i=0..3, clear key_valid, enter INIT.
REQ-013 INIT SHALL write one word per cycle for 26 cycles: S[0]=0xB7E15163, S[i]=S[i-1]+0x9E3779B9 mod 2^32.
REQ-014 MIX SHALL start with A=B=0, i=j=0 and perform one iteration per cycle for 78 cycles (3*max(T,C)).
REQ-015 Each iteration SHALL compute A'=rotl(S[i]+A+B,3), B'=rotl(L[j]+A'+B, (A'+B)[4:0]), write S[i]=A', L[j]=B', i=(i+1) mod 26, j=(j+1) mod 4.
REQ-016 All additions SHALL be modulo 2^32; rotation amount SHALL be the low 5 bits only.
REQ-017 done SHALL assert exactly 105 cycles after the edge sampling an accepted start, for one cycle, in state DONE.
REQ-018 busy SHALL be 1 in INIT and MIX, 0 in IDLE and DONE.
REQ-019 key_valid SHALL rise together with done and hold until the next accepted start or reset.
REQ-020 rd_data SHALL be S[rd_addr] when key_valid=1 and rd_addr<=25, else 32'h0.
REQ-021 start asserted in the DONE cycle SHALL be accepted: key_valid falls next cycle, INIT begins.
REQ-022 key_in changes after the start cycle SHALL not affect the schedule in progress.

Reset
REQ-023 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, key_valid=0, A=B=0, i=j=0, including mid-INIT/MIX.
REQ-024 S and L storage need not be cleared by reset; rd_data SHALL read 0 until key_valid=1.
REQ-025 start sampled while rst=0 SHALL be ignored.

Structure
REQ-026 Package rc5_pkg SHALL hold W, R, B, T, C, PW=0xB7E15163, QW=0x9E3779B9 and the FSM state enum, shared with the encoder/decoder.
REQ-027 Variable left-rotate SHALL be a sub-module rc5_rotl (W-bit data, 5-bit amount), reused by the encoder stage.
REQ-028 S SHALL be a 26x32 register array, L a 4x32 array; no external memory.

Verification
REQ-029 Reset, then start with key_in=0 -> busy high 104 cycles, done pulse at cycle 105, key_valid=1.
REQ-030 Before MIX (probe INIT end): S[0]=0xB7E15163, S[1]=0x5618CB1C, S[25]=PW+25*QW mod 2^32.
REQ-031 key_in=0 table feeding the RC5 encoder, plaintext 00000000_00000000 -> ciphertext 21A5DBEE_154B8F6D.
REQ-032 Random keys (>=100) -> all 26 rd_data words match a software key-schedule model; rd_addr 26..31 -> 0.
REQ-033 start pulsed at cycle 40 of a run -> ignored, done still at cycle 105 with original key's table.
REQ-034 rst=0 during MIX -> next cycle busy=0, key_valid=0, rd_data=0; fresh start completes normally in 105 cycles.
